// File: rtl/tcm_dual_port_mem_pkg.sv
// Shared sizing constants for the tightly-coupled memory.
package tcm_dual_port_mem_pkg;

   localparam int unsigned MEM_BYTES_DEF = 131072;
   localparam int unsigned TAG_W_DEF     = 11;

   // Bits needed to index 64-bit words in a memory of the given byte size.
   function automatic int unsigned idx_width(input int unsigned bytes);
      return $clog2(bytes / 8);
   endfunction

   localparam int unsigned IDX_W_DEF = idx_width(MEM_BYTES_DEF);

endpackage

// File: rtl/tcm_dual_port_ram.sv
// 64-bit dual-port RAM: port A read-only, port B read with byte-masked write.
module tcm_dual_port_ram
   import tcm_dual_port_mem_pkg::*;
#(
   parameter int unsigned WORDS = MEM_BYTES_DEF / 8,
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr_a,
   output logic [63:0]      rd_a,
   input  logic [IDX_W-1:0] addr_b,
   input  logic [7:0]       wr_b,
   input  logic [63:0]      data_b,
   output logic [63:0]      rd_b
);

   logic [63:0] ram [0:WORDS-1];

   // Reads sample the array before this edge's write lands: read-before-write.
   always_ff @(posedge clk) begin
      rd_a <= ram[addr_a];
      rd_b <= ram[addr_b];
      for (int unsigned i = 0; i < 8; i++) begin
         if (wr_b[i]) ram[addr_b][i*8 +: 8] <= data_b[i*8 +: 8];
      end
   end

   // Image preload path; byte-granular so several preloads in one time step compose.
   task automatic backdoor(input logic [IDX_W-1:0] idx, input logic [2:0] lane,
                           input logic [7:0] data);
      ram[idx][{lane, 3'b000} +: 8] <= data;
   endtask

endmodule

// File: rtl/tcm_dual_port_mem.sv
// Single-cycle TCM: 64-bit fetch port and tagged 32-bit load/store port.
module tcm_dual_port_mem
   import tcm_dual_port_mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
   parameter int unsigned TAG_W     = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_i_rd_i,
   input  logic             mem_i_flush_i,
   input  logic             mem_i_invalidate_i,
   input  logic [31:0]      mem_i_pc_i,
   output logic             mem_i_accept_o,
   output logic             mem_i_valid_o,
   output logic             mem_i_error_o,
   output logic [63:0]      mem_i_inst_o,
   input  logic [31:0]      mem_d_addr_i,
   input  logic [31:0]      mem_d_data_wr_i,
   input  logic             mem_d_rd_i,
   input  logic [3:0]       mem_d_wr_i,
   input  logic             mem_d_cacheable_i,
   input  logic [TAG_W-1:0] mem_d_req_tag_i,
   input  logic             mem_d_invalidate_i,
   input  logic             mem_d_writeback_i,
   input  logic             mem_d_flush_i,
   output logic [31:0]      mem_d_data_rd_o,
   output logic             mem_d_accept_o,
   output logic             mem_d_ack_o,
   output logic             mem_d_error_o,
   output logic [TAG_W-1:0] mem_d_resp_tag_o
);

   localparam int unsigned AW    = $clog2(MEM_BYTES);
   localparam int unsigned IDX_W = idx_width(MEM_BYTES);

   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] data_idx;
   logic [3:0]       be;
   logic [7:0]       lane_be;
   logic [63:0]      lane_data;
   logic [63:0]      ram_a;
   logic [63:0]      ram_b;
   logic             fetch_q;
   logic             ack_q;
   logic             load_q;
   logic             hi_q;
   logic [TAG_W-1:0] tag_q;
   logic             data_req;
   logic             unused_ok;

   assign fetch_idx = mem_i_pc_i[AW-1:3];
   assign data_idx  = mem_d_addr_i[AW-1:3];
   assign data_req  = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                    | mem_d_writeback_i | mem_d_flush_i;

   // Stores are dropped while reset is held so RAM only changes on accepted requests.
   assign be        = rst ? mem_d_wr_i : 4'b0000;
   assign lane_be   = mem_d_addr_i[2] ? {be, 4'b0000} : {4'b0000, be};
   assign lane_data = {mem_d_data_wr_i, mem_d_data_wr_i};

   tcm_dual_port_ram #(
      .WORDS (MEM_BYTES / 8),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk    (clk),
      .addr_a (fetch_idx),
      .rd_a   (ram_a),
      .addr_b (data_idx),
      .wr_b   (lane_be),
      .data_b (lane_data),
      .rd_b   (ram_b)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_q <= 1'b0;
         ack_q   <= 1'b0;
         load_q  <= 1'b0;
         hi_q    <= 1'b0;
         tag_q   <= '0;
      end else begin
         fetch_q <= mem_i_rd_i;
         ack_q   <= data_req;
         load_q  <= mem_d_rd_i;
         hi_q    <= mem_d_addr_i[2];
         if (data_req) tag_q <= mem_d_req_tag_i;
      end
   end

   assign mem_i_accept_o   = 1'b1;
   assign mem_i_error_o    = 1'b0;
   assign mem_i_valid_o    = fetch_q;
   assign mem_i_inst_o     = fetch_q ? ram_a : '0;
   assign mem_d_accept_o   = 1'b1;
   assign mem_d_error_o    = 1'b0;
   assign mem_d_ack_o      = ack_q;
   assign mem_d_resp_tag_o = tag_q;
   assign mem_d_data_rd_o  = load_q ? (hi_q ? ram_b[63:32] : ram_b[31:0]) : '0;

   assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
                        mem_d_addr_i, mem_d_cacheable_i};

   task automatic write(input logic [31:0] addr, input logic [7:0] data);
      u_ram.backdoor(addr[AW-1:3], addr[2:0], data);
   endtask

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Directed self-checking bench for tcm_dual_port_mem.
module tb_tcm_dual_port_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
   logic [31:0] mem_i_pc_i;
   logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
   logic [63:0] mem_i_inst_o;
   logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
   logic        mem_d_rd_i;
   logic [3:0]  mem_d_wr_i;
   logic        mem_d_cacheable_i;
   logic [10:0] mem_d_req_tag_i;
   logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
   logic [31:0] mem_d_data_rd_o;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [10:0] mem_d_resp_tag_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tcm_dual_port_mem #(.MEM_BYTES(131072), .TAG_W(11)) dut (
      .clk                (clk),
      .rst                (rst),
      .mem_i_rd_i         (mem_i_rd_i),
      .mem_i_flush_i      (mem_i_flush_i),
      .mem_i_invalidate_i (mem_i_invalidate_i),
      .mem_i_pc_i         (mem_i_pc_i),
      .mem_i_accept_o     (mem_i_accept_o),
      .mem_i_valid_o      (mem_i_valid_o),
      .mem_i_error_o      (mem_i_error_o),
      .mem_i_inst_o       (mem_i_inst_o),
      .mem_d_addr_i       (mem_d_addr_i),
      .mem_d_data_wr_i    (mem_d_data_wr_i),
      .mem_d_rd_i         (mem_d_rd_i),
      .mem_d_wr_i         (mem_d_wr_i),
      .mem_d_cacheable_i  (mem_d_cacheable_i),
      .mem_d_req_tag_i    (mem_d_req_tag_i),
      .mem_d_invalidate_i (mem_d_invalidate_i),
      .mem_d_writeback_i  (mem_d_writeback_i),
      .mem_d_flush_i      (mem_d_flush_i),
      .mem_d_data_rd_o    (mem_d_data_rd_o),
      .mem_d_accept_o     (mem_d_accept_o),
      .mem_d_ack_o        (mem_d_ack_o),
      .mem_d_error_o      (mem_d_error_o),
      .mem_d_resp_tag_o   (mem_d_resp_tag_o)
   );

   task automatic idle();
      mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = '0;
      mem_d_addr_i = '0; mem_d_data_wr_i = '0; mem_d_rd_i = 0; mem_d_wr_i = '0;
      mem_d_cacheable_i = 0; mem_d_req_tag_i = '0; mem_d_invalidate_i = 0;
      mem_d_writeback_i = 0; mem_d_flush_i = 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 0;
      idle();
      mem_i_rd_i = 1; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h055;
      cycle();
      cycle();
      checks++; if (mem_i_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mem_i_valid_o); end
      checks++; if (mem_d_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", mem_d_ack_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h000) begin errors++; $display("FAIL reset_tag got %h want 000", mem_d_resp_tag_o); end
      checks++; if (mem_i_inst_o !== 64'h0) begin errors++; $display("FAIL reset_inst got %h want 0", mem_i_inst_o); end
      checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", mem_d_data_rd_o); end
      checks++; if ({mem_i_accept_o, mem_i_error_o, mem_d_accept_o, mem_d_error_o} !== 4'b1010) begin
         errors++; $display("FAIL const_flags got %b want 1010", {mem_i_accept_o, mem_i_error_o, mem_d_accept_o, mem_d_error_o});
      end
      idle();
      rst = 1;
      cycle();
   endtask

   task automatic test_fetch();
      mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000; mem_i_flush_i = 1;
      cycle();
      checks++; if (mem_i_valid_o !== 1'b1) begin errors++; $display("FAIL fetch0_valid got %b want 1", mem_i_valid_o); end
      checks++; if (mem_i_inst_o !== 64'h0706050403020100) begin errors++; $display("FAIL fetch0_inst got %h want 0706050403020100", mem_i_inst_o); end
      mem_i_pc_i = 32'h8000_0008; mem_i_flush_i = 0; mem_i_invalidate_i = 1;
      cycle();
      checks++; if (mem_i_inst_o !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL fetch8_inst got %h want 0F0E0D0C0B0A0908", mem_i_inst_o); end
      idle();
      cycle();
      checks++; if (mem_i_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_drop got %b want 0", mem_i_valid_o); end
   endtask

   task automatic test_store_load();
      mem_d_addr_i = 32'h8000_0104; mem_d_data_wr_i = 32'hAABBCCDD; mem_d_wr_i = 4'b0101;
      mem_d_req_tag_i = 11'h123;
      cycle();
      checks++; if (mem_d_ack_o !== 1'b1) begin errors++; $display("FAIL store_ack got %b want 1", mem_d_ack_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h123) begin errors++; $display("FAIL store_tag got %h want 123", mem_d_resp_tag_o); end
      checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL store_rd got %h want 0", mem_d_data_rd_o); end
      idle();
      mem_d_addr_i = 32'h8000_0104; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h7FF;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h00BB00DD) begin errors++; $display("FAIL load104 got %h want 00BB00DD", mem_d_data_rd_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h7FF) begin errors++; $display("FAIL load104_tag got %h want 7FF", mem_d_resp_tag_o); end
      mem_d_addr_i = 32'h8000_0100; mem_d_req_tag_i = 11'h001;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL load100 got %h want 00000000", mem_d_data_rd_o); end
      idle();
      mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0103;
      cycle();
      checks++; if (mem_i_inst_o !== 64'h00BB00DD_00000000) begin errors++; $display("FAIL fetch100 got %h want 00BB00DD00000000", mem_i_inst_o); end
      idle();
   endtask

   task automatic test_alias();
      mem_d_addr_i = 32'h0002_0010; mem_d_data_wr_i = 32'h12345678; mem_d_wr_i = 4'b1111;
      cycle();
      idle();
      mem_d_addr_i = 32'h8000_0010; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h0AA;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h12345678) begin errors++; $display("FAIL alias got %h want 12345678", mem_d_data_rd_o); end
      idle();
   endtask

   task automatic test_collision();
      mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0020;
      mem_d_addr_i = 32'h8000_0020; mem_d_data_wr_i = 32'hCAFEF00D; mem_d_wr_i = 4'b1111;
      mem_d_rd_i = 1; mem_d_req_tag_i = 11'h321;
      cycle();
      checks++; if (mem_i_inst_o !== 64'h0) begin errors++; $display("FAIL coll_fetch_old got %h want 0", mem_i_inst_o); end
      checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL coll_load_old got %h want 0", mem_d_data_rd_o); end
      checks++; if (mem_d_ack_o !== 1'b1) begin errors++; $display("FAIL coll_ack got %b want 1", mem_d_ack_o); end
      mem_d_wr_i = 4'b0000;
      cycle();
      checks++; if (mem_i_inst_o !== 64'h00000000_CAFEF00D) begin errors++; $display("FAIL coll_fetch_new got %h want 00000000CAFEF00D", mem_i_inst_o); end
      checks++; if (mem_d_data_rd_o !== 32'hCAFEF00D) begin errors++; $display("FAIL coll_load_new got %h want CAFEF00D", mem_d_data_rd_o); end
      idle();
   endtask

   task automatic test_cache_ops();
      mem_d_flush_i = 1; mem_d_req_tag_i = 11'h44C;
      cycle();
      checks++; if (mem_d_ack_o !== 1'b1) begin errors++; $display("FAIL flush_ack got %b want 1", mem_d_ack_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h44C) begin errors++; $display("FAIL flush_tag got %h want 44C", mem_d_resp_tag_o); end
      idle();
      mem_d_writeback_i = 1; mem_d_req_tag_i = 11'h002;
      cycle();
      checks++; if (mem_d_resp_tag_o !== 11'h002) begin errors++; $display("FAIL wb_tag got %h want 002", mem_d_resp_tag_o); end
      idle();
      cycle();
      checks++; if (mem_d_ack_o !== 1'b0) begin errors++; $display("FAIL idle_ack got %b want 0", mem_d_ack_o); end
   endtask

   task automatic test_back_to_back();
      mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0000; mem_d_req_tag_i = 11'h001;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h03020100) begin errors++; $display("FAIL b2b0 got %h want 03020100", mem_d_data_rd_o); end
      mem_d_addr_i = 32'h8000_000C; mem_d_req_tag_i = 11'h002;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h0F0E0D0C) begin errors++; $display("FAIL b2b1 got %h want 0F0E0D0C", mem_d_data_rd_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h002) begin errors++; $display("FAIL b2b1_tag got %h want 002", mem_d_resp_tag_o); end
      idle();
   endtask

   task automatic test_reset_inflight();
      mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0104; mem_d_req_tag_i = 11'h0F0;
      cycle();
      checks++; if (mem_d_ack_o !== 1'b1) begin errors++; $display("FAIL pre_rst_ack got %b want 1", mem_d_ack_o); end
      rst = 0;
      mem_d_wr_i = 4'b1111; mem_d_data_wr_i = 32'hFFFFFFFF; mem_d_addr_i = 32'h8000_0000;
      cycle();
      checks++; if (mem_d_ack_o !== 1'b0) begin errors++; $display("FAIL inflight_ack got %b want 0", mem_d_ack_o); end
      checks++; if (mem_d_data_rd_o !== 32'h0) begin errors++; $display("FAIL inflight_rd got %h want 0", mem_d_data_rd_o); end
      checks++; if (mem_d_resp_tag_o !== 11'h000) begin errors++; $display("FAIL inflight_tag got %h want 000", mem_d_resp_tag_o); end
      rst = 1;
      idle();
      mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0000;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h03020100) begin errors++; $display("FAIL post_rst_word0 got %h want 03020100", mem_d_data_rd_o); end
      mem_d_addr_i = 32'h8000_0104;
      cycle();
      checks++; if (mem_d_data_rd_o !== 32'h00BB00DD) begin errors++; $display("FAIL post_rst_word104 got %h want 00BB00DD", mem_d_data_rd_o); end
      idle();
   endtask

   initial begin
      idle();
      rst = 0;
      for (int i = 0; i < 16; i++) dut.write(32'h8000_0000 + 32'(i), 8'(i));
      for (int i = 0; i < 8; i++) begin
         dut.write(32'h0000_0010 + 32'(i), 8'h00);
         dut.write(32'h0000_0020 + 32'(i), 8'h00);
         dut.write(32'h0000_0100 + 32'(i), 8'h00);
      end
      test_reset();
      test_fetch();
      test_store_load();
      test_alias();
      test_collision();
      test_cache_ops();
      test_back_to_back();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
